// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the down_timer block.
//   state_t               : timer FSM encoding (IDLE, RUN, EXPIRE)
//   DOWN_TIMER_WIDTH_DEF  : default counter / load-value width
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam int DOWN_TIMER_WIDTH_DEF = 8;

endpackage

// File: rtl/down_count_reg.sv
// WIDTH-bit down-count register with synchronous load, decrement enable
// and zero/one flags.
// Ports:
//   clk, rst (async, active-high)
//   load       : capture load_value (has priority over dec)
//   load_value : value captured on load
//   dec        : decrement by one; saturates at zero
//   value      : registered count
//   is_zero_c  : value == 0 (combinational decode of the register)
//   is_one_c   : value == 1 (combinational decode of the register)
module down_count_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             is_zero_c,
    output logic             is_one_c
);

    // Count register; the zero guard keeps the count from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !is_zero_c) begin
            value <= value - WIDTH'(1);
        end
    end

    // Flags decoded from the register for the FSM and the borrow chain.
    assign is_zero_c = (value == '0);
    assign is_one_c  = (value == WIDTH'(1));

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer: counts a programmed value down to zero,
// emits a one-cycle done pulse and a combinational cascade borrow.
// Build option: define DOWN_TIMER_RELOAD_EN for auto-reload from the
// reload register on expiry; undefined gives one-shot operation.
// Ports:
//   clk, rst (async, active-high)
//   parIn  : load value for counter and reload register
//   ld     : synchronous load strobe (highest priority after rst)
//   start  : begin counting from the current counter value
//   stop   : abort to IDLE, counter held
//   bi     : borrow-in / count enable (tie 1 when standalone)
//   parOut : current counter value
//   busy   : timer not idle (registered)
//   done   : one-cycle expiry pulse (registered)
//   bo     : borrow-out, high with the final decrement (combinational)
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DOWN_TIMER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parIn,
    input  logic             ld,
    input  logic             start,
    input  logic             stop,
    input  logic             bi,
    output logic [WIDTH-1:0] parOut,
    output logic             busy,
    output logic             done,
    output logic             bo
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload_value;
    logic [WIDTH-1:0] cnt_load_value;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_zero;
    logic             cnt_is_one;
`ifdef DOWN_TIMER_RELOAD_EN
    logic             cnt_load_sel_reload;
`endif

    // Counter datapath.
    down_count_reg #(
        .WIDTH (WIDTH)
    ) u_count (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (parOut),
        .is_zero_c  (cnt_is_zero),
        .is_one_c   (cnt_is_one)
    );

    // Reload register, written by every ld regardless of build option.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_value <= '0;
        end else if (ld) begin
            reload_value <= parIn;
        end
    end

`ifdef DOWN_TIMER_RELOAD_EN
    // Expiry reloads from the reload register; ld always uses parIn.
    assign cnt_load_value = cnt_load_sel_reload ? reload_value : parIn;
`else
    // One-shot: the reload register is kept but never consulted.
    logic unused_reload;
    assign unused_reload  = ^reload_value;
    assign cnt_load_value = parIn;
`endif

    // State register plus registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == EXPIRE);
        end
    end

    // Next-state and counter control; priority ld > stop > start > count.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
        cnt_load_sel_reload = 1'b0;
`endif
        if (ld) begin
            cnt_load   = 1'b1;
            state_next = IDLE;
        end else if (stop) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // A start at zero is dropped so RUN never sees count 0.
                    if (start && !cnt_is_zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (bi) begin
                        cnt_dec = 1'b1;
                        if (cnt_is_one) begin
                            state_next = EXPIRE;
                        end
                    end
                end
                EXPIRE: begin
`ifdef DOWN_TIMER_RELOAD_EN
                    if (reload_value != '0) begin
                        cnt_load            = 1'b1;
                        cnt_load_sel_reload = 1'b1;
                        state_next          = RUN;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Borrow-out rides with the final decrement so an upper stage can chain bi.
    assign bo = (state == RUN) && bi && cnt_is_one;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld = 1'b0, start = 1'b0, stop = 1'b0, bi = 1'b0;
    logic [7:0] parIn = 8'd0;
    logic [7:0] parOut;
    logic       busy, done, bo;

    down_timer #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .parIn  (parIn),
        .ld     (ld),
        .start  (start),
        .stop   (stop),
        .bi     (bi),
        .parOut (parOut),
        .busy   (busy),
        .done   (done),
        .bo     (bo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining count, reload value, running / expiring flags.
    int m_cnt = 0;
    int m_rel = 0;
    bit m_run = 0;
    bit m_exp = 0;

    logic [7:0] s_par;
    logic       s_busy, s_done;

    typedef struct {
        logic       l, s, sp, b;
        logic [7:0] p;
        logic [7:0] e_par;
        logic       e_busy, e_done, e_bo;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_exp = 0;
    endtask

    // Apply the edge rules to the model using the inputs currently driven.
    task automatic model_edge();
        if (ld) begin
            m_cnt = int'(parIn); m_rel = int'(parIn); m_run = 0; m_exp = 0;
        end else if (stop) begin
            m_run = 0; m_exp = 0;
        end else if (m_exp) begin
            m_exp = 0;
`ifdef DOWN_TIMER_RELOAD_EN
            if (m_rel != 0) begin
                m_cnt = m_rel; m_run = 1;
            end
`endif
        end else if (m_run) begin
            if (bi) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_run = 0; m_exp = 1;
                end
            end
        end else if (start && m_cnt != 0) begin
            m_run = 1;
        end
    endtask

    task automatic check_model();
        chk("model parOut", 32'(parOut), 32'(m_cnt));
        chk("model busy",   32'(busy),   32'(m_run | m_exp));
        chk("model done",   32'(done),   32'(m_exp));
        chk("model bo",     32'(bo),     32'(m_run && bi && (m_cnt == 1)));
    endtask

    // One cycle: drive, sample on the falling edge, advance the model on the rising edge.
    task automatic step(input logic l, input logic s, input logic sp, input logic b, input logic [7:0] p);
        ld = l; start = s; stop = sp; bi = b; parIn = p;
        @(negedge clk);
        check_model();
        s_par = parOut; s_busy = busy; s_done = done;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int dn;
        int exp_dn;

        // Reset values.
        #12;
        chk("reset parOut", 32'(parOut), 32'd0);
        chk("reset busy",   32'(busy),   32'd0);
        chk("reset done",   32'(done),   32'd0);
        chk("reset bo",     32'(bo),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // One-shot count of 5 with bi held high; expectations sampled before each edge.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd5, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0};
`ifdef DOWN_TIMER_RELOAD_EN
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd5, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0};
`else
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 10; i++) begin
            ld = tbl[i].l; start = tbl[i].s; stop = tbl[i].sp; bi = tbl[i].b; parIn = tbl[i].p;
            @(negedge clk);
            chk($sformatf("vec%0d parOut", i), 32'(parOut), 32'(tbl[i].e_par));
            chk($sformatf("vec%0d busy", i),   32'(busy),   32'(tbl[i].e_busy));
            chk($sformatf("vec%0d done", i),   32'(done),   32'(tbl[i].e_done));
            chk($sformatf("vec%0d bo", i),     32'(bo),     32'(tbl[i].e_bo));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Gated count: only bi=1 edges decrement.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("gated done pulse", 32'(s_done), 32'd1);
        chk("gated parOut", 32'(s_par), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("gated done width", 32'(s_done), 32'd0);

        // Start at zero is ignored.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("zero start busy", 32'(s_busy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("zero start done", 32'(s_done), 32'd0);

        // ld during RUN at count 4 aborts without done.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd8);
        chk("abort ld at count", 32'(s_par), 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("abort ld parOut", 32'(s_par), 32'd8);
        chk("abort ld busy", 32'(s_busy), 32'd0);
        chk("abort ld done", 32'(s_done), 32'd0);

        // stop coincident with the final decrement wins.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("stop final parOut", 32'(s_par), 32'd1);
        chk("stop final busy", 32'(s_busy), 32'd0);
        chk("stop final done", 32'(s_done), 32'd0);

        // Done pulse count over 12 cycles of a load of 3.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
            dn += int'(s_done);
        end
`ifdef DOWN_TIMER_RELOAD_EN
        exp_dn = 3;
`else
        exp_dn = 1;
`endif
        chk("done pulse count", 32'(dn), 32'(exp_dn));
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        ld = 1'b0; start = 1'b0; stop = 1'b0; bi = 1'b1;
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        chk("async rst parOut", 32'(parOut), 32'd0);
        chk("async rst busy",   32'(busy),   32'd0);
        chk("async rst done",   32'(done),   32'd0);
        chk("async rst bo",     32'(bo),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
